sw_pe_affine: RTL and testbench

Parametrised next-generation Smith-Waterman processing element for the systolic alignment array. It holds one query symbol and consumes one target symbol per valid beat. It computes the affine-gap local score H with its E/F terms using saturating signed arithmetic, and forwards target, H and F to the next PE. Compared with the first-generation PE it adds a valid/stall handshake, configurable symbol and score widths, runtime query loading, and per-PE best-score and position tracking.

---
 rtl/sw_pkg.sv | 18 +
 rtl/sw_sat_addsub.sv | 28 ++
 rtl/sw_pe_affine.sv | 158 +++++++++++++++
 tb/tb_sw_pe_affine.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman PE: score limits and traceback encoding.
package sw_pkg;

    // Most negative representable score; used as the "minus infinity" sentinel.
    function automatic int neg_inf(input int unsigned w);
        return -(2 ** (w - 1));
    endfunction

    function automatic int pos_max(input int unsigned w);
        return (2 ** (w - 1)) - 1;
    endfunction

    localparam logic [1:0] TB_STOP = 2'b00;
    localparam logic [1:0] TB_DIAG = 2'b01;
    localparam logic [1:0] TB_UP   = 2'b10;
    localparam logic [1:0] TB_LEFT = 2'b11;

endpackage

// File: rtl/sw_sat_addsub.sv
// Saturating signed add/subtract; result clamps to [-2^(W-1), 2^(W-1)-1].
module sw_sat_addsub #(
    parameter int unsigned W = 12
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                sub_en,
    output logic signed [W-1:0] y
);

    logic signed [W:0] a_x;
    logic signed [W:0] b_x;
    logic signed [W:0] r_x;

    assign a_x = {a[W-1], a};
    assign b_x = {b[W-1], b};

    always_comb begin
        r_x = sub_en ? (a_x - b_x) : (a_x + b_x);
        // One guard bit is enough: overflow shows up as disagreeing top bits.
        if (r_x[W] != r_x[W-1]) begin
            y = r_x[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            y = r_x[W-1:0];
        end
    end

endmodule

// File: rtl/sw_pe_affine.sv
// Affine-gap Smith-Waterman processing element with valid/stall, query load and best tracking.
// Optional traceback output enabled by defining SW_PE_TRACEBACK_EN.
module sw_pe_affine
    import sw_pkg::*;
#(
    parameter int unsigned SCORE_W = 12,
    parameter int unsigned SYM_W   = 2,
    parameter int unsigned POS_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_en,
    input  logic [SYM_W-1:0]          load_sym,
    input  logic                      in_valid,
    input  logic                      in_first,
    input  logic [SYM_W-1:0]          t_in,
    input  logic signed [SCORE_W-1:0] h_in,
    input  logic signed [SCORE_W-1:0] f_in,
    input  logic signed [SCORE_W-1:0] match,
    input  logic signed [SCORE_W-1:0] mismatch,
    input  logic signed [SCORE_W-1:0] gap_open,
    input  logic signed [SCORE_W-1:0] gap_ext,
    output logic                      out_valid,
    output logic                      out_first,
    output logic [SYM_W-1:0]          t_out,
    output logic signed [SCORE_W-1:0] h_out,
    output logic signed [SCORE_W-1:0] f_out,
    output logic signed [SCORE_W-1:0] best_score,
    output logic [POS_W-1:0]          best_pos
`ifdef SW_PE_TRACEBACK_EN
    ,
    output logic [1:0]                tb_dir
`endif
);

    localparam logic signed [SCORE_W-1:0] NEG_INF = SCORE_W'(neg_inf(SCORE_W));

    function automatic logic signed [SCORE_W-1:0] smax(
        input logic signed [SCORE_W-1:0] a,
        input logic signed [SCORE_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [SYM_W-1:0]          q_sym_q;
    logic signed [SCORE_W-1:0] h_diag_q, e_prev_q;
    logic [POS_W-1:0]          pos_q, pos_d;
    logic signed [SCORE_W-1:0] best_score_q, best_score_d;
    logic [POS_W-1:0]          best_pos_q, best_pos_d;
    logic                      out_valid_q, out_first_q;
    logic [SYM_W-1:0]          t_out_q;
    logic signed [SCORE_W-1:0] h_out_q, f_out_q;

    logic signed [SCORE_W-1:0] hd, hp, ep, sub;
    logic signed [SCORE_W-1:0] d_val, e_ext, e_open, f_ext, f_open;
    logic signed [SCORE_W-1:0] e_val, f_val, h_val;

    // h_out_q is this PE's H from the last accepted beat, so it doubles as h_prev.
    assign hd  = in_first ? '0 : h_diag_q;
    assign hp  = in_first ? '0 : h_out_q;
    assign ep  = in_first ? NEG_INF : e_prev_q;
    assign sub = (t_in == q_sym_q) ? match : mismatch;

    sw_sat_addsub #(.W(SCORE_W)) u_d      (.a(hd),   .b(sub),      .sub_en(1'b0), .y(d_val));
    sw_sat_addsub #(.W(SCORE_W)) u_e_ext  (.a(ep),   .b(gap_ext),  .sub_en(1'b1), .y(e_ext));
    sw_sat_addsub #(.W(SCORE_W)) u_e_open (.a(hp),   .b(gap_open), .sub_en(1'b1), .y(e_open));
    sw_sat_addsub #(.W(SCORE_W)) u_f_ext  (.a(f_in), .b(gap_ext),  .sub_en(1'b1), .y(f_ext));
    sw_sat_addsub #(.W(SCORE_W)) u_f_open (.a(h_in), .b(gap_open), .sub_en(1'b1), .y(f_open));

    always_comb begin
        e_val = smax(e_ext, e_open);
        f_val = smax(f_ext, f_open);
        h_val = smax(smax('0, d_val), smax(e_val, f_val));

        if (in_first) begin
            pos_d = '0;
        end else if (pos_q == '1) begin
            pos_d = pos_q;
        end else begin
            pos_d = pos_q + 1'b1;
        end

        best_score_d = best_score_q;
        best_pos_d   = best_pos_q;
        if (in_first || (h_val > best_score_q)) begin
            best_score_d = h_val;
            best_pos_d   = pos_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_sym_q      <= '0;
            h_diag_q     <= '0;
            e_prev_q     <= NEG_INF;
            pos_q        <= '0;
            best_score_q <= '0;
            best_pos_q   <= '0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            t_out_q      <= '0;
            h_out_q      <= '0;
            f_out_q      <= '0;
        end else begin
            out_valid_q <= in_valid;
            out_first_q <= in_valid & in_first;
            if (load_en) begin
                q_sym_q <= load_sym;
            end
            if (in_valid) begin
                h_diag_q     <= h_in;
                e_prev_q     <= e_val;
                pos_q        <= pos_d;
                best_score_q <= best_score_d;
                best_pos_q   <= best_pos_d;
                t_out_q      <= t_in;
                h_out_q      <= h_val;
                f_out_q      <= f_val;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_first  = out_first_q;
    assign t_out      = t_out_q;
    assign h_out      = h_out_q;
    assign f_out      = f_out_q;
    assign best_score = best_score_q;
    assign best_pos   = best_pos_q;

`ifdef SW_PE_TRACEBACK_EN
    logic [1:0] tb_dir_q, tb_dir_d;

    // Priority diag > up > left; stop only when no source is positive.
    always_comb begin
        if ((d_val > 0) && (d_val >= e_val) && (d_val >= f_val)) begin
            tb_dir_d = TB_DIAG;
        end else if ((e_val > 0) && (e_val >= f_val)) begin
            tb_dir_d = TB_UP;
        end else if (f_val > 0) begin
            tb_dir_d = TB_LEFT;
        end else begin
            tb_dir_d = TB_STOP;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tb_dir_q <= TB_STOP;
        end else if (in_valid) begin
            tb_dir_q <= tb_dir_d;
        end
    end

    assign tb_dir = tb_dir_q;
`endif

endmodule

// File: tb/tb_sw_pe_affine.sv
// Directed self-checking bench for sw_pe_affine (traceback checks when SW_PE_TRACEBACK_EN is defined).
module tb_sw_pe_affine;

    localparam int NEG = -2048;
    localparam int PMAX = 2047;
    localparam logic [1:0] SA = 2'd0, SC = 2'd1, SG = 2'd2;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               load_en = 1'b0;
    logic [1:0]         load_sym = '0;
    logic               in_valid = 1'b0;
    logic               in_first = 1'b0;
    logic [1:0]         t_in = '0;
    logic signed [11:0] h_in = '0, f_in = '0;
    logic signed [11:0] match = '0, mismatch = '0, gap_open = '0, gap_ext = '0;
    logic               out_valid, out_first;
    logic [1:0]         t_out;
    logic signed [11:0] h_out, f_out, best_score;
    logic [15:0]        best_pos;
`ifdef SW_PE_TRACEBACK_EN
    logic [1:0]         tb_dir;
`endif

    int tests = 0;
    int fails = 0;

    sw_pe_affine #(.SCORE_W(12), .SYM_W(2), .POS_W(16)) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_sym(load_sym),
        .in_valid(in_valid), .in_first(in_first), .t_in(t_in),
        .h_in(h_in), .f_in(f_in), .match(match), .mismatch(mismatch),
        .gap_open(gap_open), .gap_ext(gap_ext),
        .out_valid(out_valid), .out_first(out_first), .t_out(t_out),
        .h_out(h_out), .f_out(f_out), .best_score(best_score), .best_pos(best_pos)
`ifdef SW_PE_TRACEBACK_EN
        , .tb_dir(tb_dir)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic scores(input int m, input int mm, input int go, input int ge);
        match = 12'(m); mismatch = 12'(mm); gap_open = 12'(go); gap_ext = 12'(ge);
    endtask

    task automatic beat(input logic first, input logic [1:0] t, input int h, input int f);
        in_valid = 1'b1; in_first = first; t_in = t; h_in = 12'(h); f_in = 12'(f);
        @(posedge clk); #1;
    endtask

    task automatic idle(input logic first);
        in_valid = 1'b0; in_first = first; t_in = SG; h_in = 12'(99); f_in = 12'(99);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #2;
        check("rst_h", h_out, 0);
        check("rst_f", f_out, 0);
        check("rst_best", best_score, 0);
        check("rst_pos", best_pos, 0);
        check("rst_valid", out_valid, 0);
`ifdef SW_PE_TRACEBACK_EN
        check("rst_tb", tb_dir, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        load_en = 1'b1; load_sym = SA;
        idle(1'b0);
        load_en = 1'b0;
        check("idle_valid", out_valid, 0);

        // DNA match streak
        scores(2, -1, 3, 1);
        beat(1'b1, SA, 0, 0);
        check("dna0_h", h_out, 2);
        check("dna0_f", f_out, -1);
        check("dna0_first", out_first, 1);
        check("dna0_valid", out_valid, 1);
        check("dna0_t", t_out, SA);
        beat(1'b0, SA, 0, 0);
        check("dna1_h", h_out, 2);
        check("dna1_first", out_first, 0);
        beat(1'b0, SA, 0, 0);
        check("dna2_h", h_out, 2);
        check("dna2_best", best_score, 2);
        check("dna2_pos", best_pos, 0);

        // F gap open then saturating extension
        beat(1'b1, SC, 10, NEG);
        check("gapf0_f", f_out, 7);
        check("gapf0_h", h_out, 7);
        beat(1'b0, SC, NEG, NEG);
        check("gapf1_f", f_out, NEG);
        check("gapf1_h", h_out, 9);
        check("gapf1_best", best_score, 9);
        check("gapf1_pos", best_pos, 1);

        // E extension after H=10 followed by mismatches
        scores(10, -1, 3, 1);
        beat(1'b1, SA, NEG, NEG);
        check("gape0_h", h_out, 10);
        check("gape0_f", f_out, NEG);
        beat(1'b0, SC, NEG, NEG);
        check("gape1_h", h_out, 7);
        beat(1'b0, SC, NEG, NEG);
        check("gape2_h", h_out, 6);
        beat(1'b0, SC, NEG, NEG);
        check("gape3_h", h_out, 5);
        check("gape3_best", best_score, 10);
        check("gape3_pos", best_pos, 0);

        // Positive saturation, then negative sum clamped to zero
        scores(PMAX, -5, 3, 1);
        beat(1'b1, SA, PMAX, NEG);
        check("sat0_h", h_out, PMAX);
        beat(1'b0, SA, 0, NEG);
        check("sat1_h", h_out, PMAX);
        check("sat1_best", best_score, PMAX);
        beat(1'b1, SC, NEG, NEG);
        check("clamp_h", h_out, 0);
        check("clamp_best", best_score, 0);

        // Stall mid-alignment; stalled in_first must be ignored
        scores(2, -1, 3, 1);
        beat(1'b1, SA, 4, 0);
        check("st0_h", h_out, 2);
        check("st0_f", f_out, 1);
        beat(1'b0, SA, 5, 2);
        check("st1_h", h_out, 6);
        check("st1_pos", best_pos, 1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b1);
            check("stall_valid", out_valid, 0);
            check("stall_first", out_first, 0);
            check("stall_h", h_out, 6);
            check("stall_f", f_out, 2);
            check("stall_best", best_score, 6);
            check("stall_pos", best_pos, 1);
        end
        beat(1'b0, SG, 1, 0);
        check("st2_h", h_out, 4);
        check("st2_f", f_out, -1);
        check("st2_best", best_score, 6);
        beat(1'b0, SA, 0, 0);
        check("st3_h", h_out, 3);
        check("st3_pos", best_pos, 1);

        // Load in the same cycle as a beat uses the old symbol
        load_en = 1'b1; load_sym = SC;
        beat(1'b0, SA, 0, 0);
        load_en = 1'b0;
        check("load_old_h", h_out, 2);
        beat(1'b1, SC, 0, 0);
        check("new0_h", h_out, 2);
        check("new0_best", best_score, 2);
        check("new0_pos", best_pos, 0);
        beat(1'b0, SA, 0, 0);
        check("new1_h", h_out, 0);
        beat(1'b0, SC, 0, 0);
        check("new2_pos", best_pos, 0);
        beat(1'b0, SC, 5, 0);
        check("new3_f", f_out, 2);
        beat(1'b0, SC, 0, 0);
        check("new4_h", h_out, 7);
        check("new4_best", best_score, 7);
        check("new4_pos", best_pos, 4);

`ifdef SW_PE_TRACEBACK_EN
        beat(1'b1, SG, 11, NEG);
        check("tb_left_h", h_out, 8);
        check("tb_left", tb_dir, 3);
        scores(-6, -1, 3, 1);
        beat(1'b0, SC, NEG, NEG);
        check("tb_tie_h", h_out, 5);
        check("tb_tie", tb_dir, 1);
        beat(1'b1, SC, NEG, NEG);
        check("tb_stop_h", h_out, 0);
        check("tb_stop", tb_dir, 0);
        scores(2, -1, 3, 1);
        idle(1'b0);
        check("tb_hold", tb_dir, 0);
`endif

        // Asynchronous reset mid-stream, observed before any clock edge
        beat(1'b1, SC, 9, 0);
        check("pre_rst_h", h_out, 6);
        #2;
        rst = 1'b0;
        #1;
        check("arst_h", h_out, 0);
        check("arst_f", f_out, 0);
        check("arst_best", best_score, 0);
        check("arst_pos", best_pos, 0);
        check("arst_valid", out_valid, 0);
        check("arst_first", out_first, 0);
        check("arst_t", t_out, 0);
`ifdef SW_PE_TRACEBACK_EN
        check("arst_tb", tb_dir, 0);
`endif
        in_valid = 1'b0;
        #10;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
